// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-side stage of an AHB3-Lite multi-layer switch: address decode, hold of un-granted
// phases, decode-error response and can_switch generation. Optional: AHB3LITE_IC_DECERR_CNT_EN.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SLAVES     = 8
) (
    input  logic                                HRESETn,
    input  logic                                HCLK,
    input  logic                                mstHSEL,
    input  logic [HADDR_SIZE-1:0]               mstHADDR,
    input  logic [HDATA_SIZE-1:0]               mstHWDATA,
    input  logic                                mstHWRITE,
    input  logic [2:0]                          mstHSIZE,
    input  logic [2:0]                          mstHBURST,
    input  logic [3:0]                          mstHPROT,
    input  logic [1:0]                          mstHTRANS,
    input  logic                                mstHMASTLOCK,
    input  logic                                mstHREADY,
    output logic [HDATA_SIZE-1:0]               mstHRDATA,
    output logic                                mstHREADYOUT,
    output logic                                mstHRESP,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0]   slvHADDRbase,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0]   slvHADDRmask,
    output logic [SLAVES-1:0]                   slvHSEL,
    output logic [HADDR_SIZE-1:0]               slvHADDR,
    output logic [HDATA_SIZE-1:0]               slvHWDATA,
    output logic                                slvHWRITE,
    output logic [2:0]                          slvHSIZE,
    output logic [2:0]                          slvHBURST,
    output logic [3:0]                          slvHPROT,
    output logic [1:0]                          slvHTRANS,
    output logic                                slvHMASTLOCK,
    output logic                                slvHREADY,
    input  logic [SLAVES-1:0][HDATA_SIZE-1:0]   slvHRDATA,
    input  logic [SLAVES-1:0]                   slvHREADYOUT,
    input  logic [SLAVES-1:0]                   slvHRESP,
    output logic [SLAVES-1:0]                   can_switch,
    input  logic [SLAVES-1:0]                   granted
`ifdef AHB3LITE_IC_DECERR_CNT_EN
    ,
    output logic [7:0]                          decerr_cnt
`endif
);

    localparam int SLAVE_BITS = $clog2(SLAVES + 1);
    localparam logic [SLAVE_BITS-1:0] NO_SLV = SLAVE_BITS'(SLAVES);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [SLAVES-1:0] ONE = {{(SLAVES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_PASS, ST_HOLD, ST_ERR1, ST_ERR2} state_t;

    state_t                  state_q;
    logic [HADDR_SIZE-1:0]   hold_addr_q;
    logic                    hold_write_q;
    logic [2:0]              hold_size_q;
    logic [2:0]              hold_burst_q;
    logic [3:0]              hold_prot_q;
    logic [1:0]              hold_trans_q;
    logic                    hold_lock_q;
    logic [SLAVE_BITS-1:0]   hold_slv_q;
    logic [SLAVE_BITS-1:0]   data_slv_q;
    logic [SLAVE_BITS-1:0]   cur_slv_q;
    logic                    lock_q;

    logic [SLAVE_BITS-1:0]   dec_slv;
    logic                    no_slv;
    logic                    valid;
    logic                    dp_pend, dp_ready, dp_resp;
    logic [HDATA_SIZE-1:0]   dp_rdata;
    logic                    dec_gnt, dec_rdy, hold_gnt, hold_rdy;
    logic                    pass_issue, hold_issue;

    // Lowest-numbered matching slave wins.
    always_comb begin
        dec_slv = NO_SLV;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((mstHADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s]))
                dec_slv = SLAVE_BITS'(s);
        end
    end

    assign no_slv = (dec_slv == NO_SLV);
    assign valid  = mstHSEL & mstHREADY & mstHTRANS[1];

    always_comb begin
        dp_pend  = 1'b0;
        dp_ready = 1'b1;
        dp_resp  = 1'b0;
        dp_rdata = '0;
        dec_gnt  = 1'b0;
        dec_rdy  = 1'b0;
        hold_gnt = 1'b0;
        hold_rdy = 1'b0;
        for (int s = 0; s < SLAVES; s++) begin
            if (data_slv_q == SLAVE_BITS'(s)) begin
                dp_pend  = 1'b1;
                dp_ready = slvHREADYOUT[s];
                dp_resp  = slvHRESP[s];
                dp_rdata = slvHRDATA[s];
            end
            if (dec_slv == SLAVE_BITS'(s)) begin
                dec_gnt = granted[s];
                dec_rdy = slvHREADYOUT[s];
            end
            if (hold_slv_q == SLAVE_BITS'(s)) begin
                hold_gnt = granted[s];
                hold_rdy = slvHREADYOUT[s];
            end
        end
    end

    assign pass_issue = valid & ~no_slv & dec_gnt & dec_rdy;
    assign hold_issue = hold_gnt & hold_rdy & dp_ready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_PASS;
            hold_addr_q  <= '0;
            hold_write_q <= 1'b0;
            hold_size_q  <= '0;
            hold_burst_q <= '0;
            hold_prot_q  <= '0;
            hold_trans_q <= HT_IDLE;
            hold_lock_q  <= 1'b0;
            hold_slv_q   <= NO_SLV;
            data_slv_q   <= NO_SLV;
            cur_slv_q    <= NO_SLV;
            lock_q       <= 1'b0;
        end else begin
            if (dp_pend && dp_ready)
                data_slv_q <= NO_SLV;
            case (state_q)
                ST_PASS: begin
                    // IDLE/BUSY phases also refresh the lock so an unlocking IDLE releases it.
                    if (mstHSEL && mstHREADY && (!valid || pass_issue))
                        lock_q <= mstHMASTLOCK;
                    if (valid) begin
                        if (no_slv) begin
                            state_q <= ST_ERR1;
                        end else if (pass_issue) begin
                            data_slv_q <= dec_slv;
                            cur_slv_q  <= dec_slv;
                        end else begin
                            hold_addr_q  <= mstHADDR;
                            hold_write_q <= mstHWRITE;
                            hold_size_q  <= mstHSIZE;
                            hold_burst_q <= mstHBURST;
                            hold_prot_q  <= mstHPROT;
                            hold_trans_q <= mstHTRANS;
                            hold_lock_q  <= mstHMASTLOCK;
                            hold_slv_q   <= dec_slv;
                            state_q      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_issue) begin
                        data_slv_q <= hold_slv_q;
                        cur_slv_q  <= hold_slv_q;
                        lock_q     <= hold_lock_q;
                        state_q    <= ST_PASS;
                    end
                end
                ST_ERR1: state_q <= ST_ERR2;
                default: state_q <= ST_PASS;
            endcase
        end
    end

`ifdef AHB3LITE_IC_DECERR_CNT_EN
    logic [7:0] decerr_cnt_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            decerr_cnt_q <= 8'd0;
        else if (state_q == ST_PASS && valid && no_slv && decerr_cnt_q != 8'hFF)
            decerr_cnt_q <= decerr_cnt_q + 8'd1;
    end

    assign decerr_cnt = decerr_cnt_q;
`endif

    assign slvHWDATA = mstHWDATA;

    always_comb begin
        slvHSEL      = '0;
        slvHADDR     = mstHADDR;
        slvHWRITE    = mstHWRITE;
        slvHSIZE     = mstHSIZE;
        slvHBURST    = mstHBURST;
        slvHPROT     = mstHPROT;
        slvHTRANS    = mstHTRANS;
        slvHMASTLOCK = mstHMASTLOCK;
        slvHREADY    = mstHREADY;
        mstHREADYOUT = dp_ready;
        mstHRESP     = dp_resp;
        mstHRDATA    = dp_rdata;
        case (state_q)
            ST_PASS: begin
                if (mstHSEL && mstHTRANS != HT_IDLE && !no_slv)
                    slvHSEL = ONE << dec_slv;
            end
            ST_HOLD: begin
                slvHSEL      = ONE << hold_slv_q;
                slvHADDR     = hold_addr_q;
                slvHWRITE    = hold_write_q;
                slvHSIZE     = hold_size_q;
                slvHBURST    = hold_burst_q;
                slvHPROT     = hold_prot_q;
                // The burst continuity is broken by the hold, so the arbiter sees a fresh NONSEQ.
                slvHTRANS    = (hold_trans_q == HT_SEQ) ? HT_NONSEQ : hold_trans_q;
                slvHMASTLOCK = hold_lock_q;
                slvHREADY    = hold_rdy & dp_ready;
                mstHREADYOUT = 1'b0;
                mstHRESP     = 1'b0;
            end
            ST_ERR1: begin
                mstHREADYOUT = 1'b0;
                mstHRESP     = 1'b1;
            end
            default: begin
                mstHREADYOUT = 1'b1;
                mstHRESP     = 1'b1;
            end
        endcase
        if (!HRESETn) begin
            slvHSEL   = '0;
            slvHTRANS = HT_IDLE;
        end
    end

    always_comb begin
        for (int s = 0; s < SLAVES; s++) begin
            can_switch[s] = ~(dp_pend && data_slv_q == SLAVE_BITS'(s))
                          & ~(lock_q && cur_slv_q == SLAVE_BITS'(s))
                          & ~(cur_slv_q == SLAVE_BITS'(s) && mstHTRANS[0]);
        end
        if (!HRESETn)
            can_switch = '1;
    end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Directed bench for ahb3lite_interconnect_master_port; master HREADY is looped back from HREADYOUT.
module tb_ahb3lite_interconnect_master_port;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic              HRESETn = 1'b1;
    logic              HCLK    = 1'b0;
    logic              mstHSEL, mstHWRITE, mstHMASTLOCK;
    logic [31:0]       mstHADDR, mstHWDATA;
    logic [2:0]        mstHSIZE, mstHBURST;
    logic [3:0]        mstHPROT;
    logic [1:0]        mstHTRANS;
    logic [31:0]       mstHRDATA;
    logic              mstHREADYOUT, mstHRESP;
    logic [7:0][31:0]  slvHADDRbase, slvHADDRmask, slvHRDATA;
    logic [7:0]        slvHSEL, slvHREADYOUT, slvHRESP, can_switch, granted;
    logic [31:0]       slvHADDR, slvHWDATA;
    logic              slvHWRITE, slvHMASTLOCK, slvHREADY;
    logic [2:0]        slvHSIZE, slvHBURST;
    logic [3:0]        slvHPROT;
    logic [1:0]        slvHTRANS;
`ifdef AHB3LITE_IC_DECERR_CNT_EN
    logic [7:0]        decerr_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ahb3lite_interconnect_master_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .SLAVES(8)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE),
        .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADYOUT),
        .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slvHADDRbase(slvHADDRbase), .slvHADDRmask(slvHADDRmask),
        .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHWRITE(slvHWRITE),
        .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS),
        .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY),
        .slvHRDATA(slvHRDATA), .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP),
        .can_switch(can_switch), .granted(granted)
`ifdef AHB3LITE_IC_DECERR_CNT_EN
        , .decerr_cnt(decerr_cnt)
`endif
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mst(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] bu,
                       input logic lk);
        mstHSEL      = 1'b1;
        mstHTRANS    = tr;
        mstHADDR     = a;
        mstHBURST    = bu;
        mstHMASTLOCK = lk;
    endtask

    task automatic test_reset();
        #1 HRESETn = 1'b0;
        @(negedge HCLK);
        checks++; if (mstHREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got=%b exp=1", mstHREADYOUT); end
        checks++; if (mstHRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got=%b exp=0", mstHRESP); end
        checks++; if (mstHRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got=%h exp=0", mstHRDATA); end
        checks++; if (slvHSEL !== 8'h00) begin errors++; $display("FAIL rst_slvhsel got=%h exp=00", slvHSEL); end
        checks++; if (slvHTRANS !== IDLE) begin errors++; $display("FAIL rst_slvhtrans got=%b exp=00", slvHTRANS); end
        checks++; if (can_switch !== 8'hFF) begin errors++; $display("FAIL rst_can_switch got=%h exp=ff", can_switch); end
`ifdef AHB3LITE_IC_DECERR_CNT_EN
        checks++; if (decerr_cnt !== 8'd0) begin errors++; $display("FAIL rst_decerr got=%0d exp=0", decerr_cnt); end
`endif
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic_read();
        granted = 8'h02;
        mst(NONSEQ, 32'h1004, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if (slvHSEL !== 8'h02) begin errors++; $display("FAIL t1_slvhsel got=%h exp=02", slvHSEL); end
        checks++; if (slvHADDR !== 32'h1004) begin errors++; $display("FAIL t1_slvhaddr got=%h exp=1004", slvHADDR); end
        checks++; if (mstHREADYOUT !== 1'b1) begin errors++; $display("FAIL t1_addr_hready got=%b exp=1", mstHREADYOUT); end
        tick();
        mst(IDLE, 32'h0, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if (mstHRDATA !== 32'hD000_0001) begin errors++; $display("FAIL t1_hrdata got=%h exp=d0000001", mstHRDATA); end
        checks++; if (mstHREADYOUT !== 1'b1) begin errors++; $display("FAIL t1_data_hready got=%b exp=1", mstHREADYOUT); end
        checks++; if (can_switch !== 8'hFD) begin errors++; $display("FAIL t1_can_switch got=%h exp=fd", can_switch); end
        tick();
        @(negedge HCLK);
        checks++; if (can_switch !== 8'hFF) begin errors++; $display("FAIL t1_can_switch_idle got=%h exp=ff", can_switch); end
        checks++; if (mstHRDATA !== 32'h0) begin errors++; $display("FAIL t1_hrdata_idle got=%h exp=0", mstHRDATA); end
        tick();
    endtask

    task automatic test_hold();
        int low_cycles = 0;
        granted = 8'h00;
        mst(NONSEQ, 32'h1004, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if (mstHREADYOUT !== 1'b1) begin errors++; $display("FAIL t2_capture_hready got=%b exp=1", mstHREADYOUT); end
        tick();
        mst(IDLE, 32'h0, 3'b000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) granted = 8'h02;
            @(negedge HCLK);
            if (mstHREADYOUT === 1'b0) low_cycles++;
            checks++; if (slvHADDR !== 32'h1004) begin errors++; $display("FAIL t2_held_addr c%0d got=%h exp=1004", c, slvHADDR); end
            checks++; if (slvHSEL !== 8'h02) begin errors++; $display("FAIL t2_held_hsel c%0d got=%h exp=02", c, slvHSEL); end
            tick();
        end
        @(negedge HCLK);
        if (mstHREADYOUT === 1'b0) low_cycles++;
        checks++; if (low_cycles != 3) begin errors++; $display("FAIL t2_wait_cycles got=%0d exp=3", low_cycles); end
        checks++; if (mstHRDATA !== 32'hD000_0001) begin errors++; $display("FAIL t2_hrdata got=%h exp=d0000001", mstHRDATA); end
        tick();
    endtask

    task automatic test_held_seq();
        granted = 8'h04;
        mst(NONSEQ, 32'h2000, 3'b001, 1'b0);
        tick();
        granted = 8'h00;
        mst(SEQ, 32'h2004, 3'b001, 1'b0);
        @(negedge HCLK);
        checks++; if (slvHTRANS !== SEQ) begin errors++; $display("FAIL t3_live_seq got=%b exp=11", slvHTRANS); end
        tick();
        granted = 8'h04;
        mst(SEQ, 32'h2008, 3'b001, 1'b0);
        @(negedge HCLK);
        checks++; if (slvHTRANS !== NONSEQ) begin errors++; $display("FAIL t3_held_trans got=%b exp=10", slvHTRANS); end
        checks++; if (slvHADDR !== 32'h2004) begin errors++; $display("FAIL t3_held_addr got=%h exp=2004", slvHADDR); end
        checks++; if (mstHREADYOUT !== 1'b0) begin errors++; $display("FAIL t3_issue_hready got=%b exp=0", mstHREADYOUT); end
        tick();
        @(negedge HCLK);
        checks++; if (slvHTRANS !== SEQ) begin errors++; $display("FAIL t3_next_seq got=%b exp=11", slvHTRANS); end
        checks++; if (slvHADDR !== 32'h2008) begin errors++; $display("FAIL t3_next_addr got=%h exp=2008", slvHADDR); end
        checks++; if (mstHRDATA !== 32'hD000_0002) begin errors++; $display("FAIL t3_hrdata got=%h exp=d0000002", mstHRDATA); end
        tick();
        mst(IDLE, 32'h0, 3'b000, 1'b0);
        tick();
    endtask

    task automatic test_decode_error();
        granted = 8'h02;
        mst(NONSEQ, 32'h0000_F000, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if (slvHSEL !== 8'h00) begin errors++; $display("FAIL t4_slvhsel got=%h exp=00", slvHSEL); end
        tick();
        mst(IDLE, 32'h0, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if ({mstHRESP, mstHREADYOUT} !== 2'b10) begin errors++; $display("FAIL t4_err1 got=%b exp=10", {mstHRESP, mstHREADYOUT}); end
        tick();
        mst(NONSEQ, 32'h1008, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if ({mstHRESP, mstHREADYOUT} !== 2'b11) begin errors++; $display("FAIL t4_err2 got=%b exp=11", {mstHRESP, mstHREADYOUT}); end
        checks++; if (slvHSEL !== 8'h00) begin errors++; $display("FAIL t4_err2_hsel got=%h exp=00", slvHSEL); end
        tick();
        mst(IDLE, 32'h0, 3'b000, 1'b0);
        @(negedge HCLK);
        checks++; if ({mstHRESP, mstHREADYOUT} !== 2'b01) begin errors++; $display("FAIL t4_after got=%b exp=01", {mstHRESP, mstHREADYOUT}); end
        checks++; if (mstHRDATA !== 32'h0) begin errors++; $display("FAIL t4_no_dataphase got=%h exp=0", mstHRDATA); end
`ifdef AHB3LITE_IC_DECERR_CNT_EN
        checks++; if (decerr_cnt !== 8'd1) begin errors++; $display("FAIL t4_decerr got=%0d exp=1", decerr_cnt); end
`endif
        tick();
    endtask

    task automatic test_locked_burst();
        logic [7:0] exp_cs [0:5];
        exp_cs = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
        granted = 8'h01;
        for (int b = 0; b < 6; b++) begin
            if (b == 0)      mst(NONSEQ, 32'h0, 3'b011, 1'b1);
            else if (b < 4)  mst(SEQ, 32'(b * 4), 3'b011, 1'b1);
            else             mst(IDLE, 32'h0, 3'b000, 1'b0);
            @(negedge HCLK);
            if (b > 0) begin
                checks++;
                if (can_switch !== exp_cs[b]) begin
                    errors++; $display("FAIL t5_can_switch beat%0d got=%h exp=%h", b, can_switch, exp_cs[b]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_in_hold();
        granted = 8'h00;
        mst(NONSEQ, 32'h1004, 3'b000, 1'b0);
        tick();
        @(negedge HCLK);
        checks++; if (mstHREADYOUT !== 1'b0) begin errors++; $display("FAIL t6_in_hold got=%b exp=0", mstHREADYOUT); end
        #1 HRESETn = 1'b0;
        #1;
        checks++; if (mstHREADYOUT !== 1'b1) begin errors++; $display("FAIL t6_hreadyout got=%b exp=1", mstHREADYOUT); end
        checks++; if (slvHSEL !== 8'h00) begin errors++; $display("FAIL t6_slvhsel got=%h exp=00", slvHSEL); end
        checks++; if (slvHTRANS !== IDLE) begin errors++; $display("FAIL t6_slvhtrans got=%b exp=00", slvHTRANS); end
        checks++; if (can_switch !== 8'hFF) begin errors++; $display("FAIL t6_can_switch got=%h exp=ff", can_switch); end
        checks++; if (mstHRESP !== 1'b0) begin errors++; $display("FAIL t6_hresp got=%b exp=0", mstHRESP); end
        granted = 8'h02;
        mst(IDLE, 32'h0, 3'b000, 1'b0);
        tick();
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++; if (slvHSEL !== 8'h00) begin errors++; $display("FAIL t6_no_issue got=%h exp=00", slvHSEL); end
        tick();
        @(negedge HCLK);
        checks++; if (mstHRDATA !== 32'h0) begin errors++; $display("FAIL t6_no_data got=%h exp=0", mstHRDATA); end
        tick();
    endtask

    initial begin
        mstHSEL = 1'b0; mstHWRITE = 1'b0; mstHMASTLOCK = 1'b0;
        mstHADDR = '0; mstHWDATA = 32'hCAFE_0000;
        mstHSIZE = 3'b010; mstHBURST = '0; mstHPROT = 4'b0011; mstHTRANS = IDLE;
        granted = '0; slvHREADYOUT = '1; slvHRESP = '0;
        for (int s = 0; s < 8; s++) begin
            slvHADDRbase[s] = 32'(s) << 12;
            slvHADDRmask[s] = 32'h0000_F000;
            slvHRDATA[s]    = 32'hD000_0000 + 32'(s);
        end
        test_reset();
        test_basic_read();
        test_hold();
        test_held_seq();
        test_decode_error();
        test_locked_burst();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
